// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_pkg : FSM state encoding and RAM opcode constants for the SPI slave.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_shift_reg : MSB-first shift register with parallel load and clear.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic             i_sdata,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_clear) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], i_sdata};
    end
  end

  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_slave : SPI front end issuing RAM commands and returning read data.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module spi_slave
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 MOSI,
  input  logic                 SS_n,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int                c_FRAME_BITS = ADDR_SIZE + 2;
  localparam int                c_CNT_W      = $clog2(c_FRAME_BITS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(c_FRAME_BITS - 1);
  localparam logic [c_CNT_W-1:0] c_DONE      = c_CNT_W'(c_FRAME_BITS);

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_rx_valid;
  logic                 r_rd_addr_received;
  logic                 r_tx_loaded;

  logic                 w_in_frame;
  logic                 w_rx_shift;
  logic                 w_tx_load;
  logic                 w_tx_shift;
  logic [ADDR_SIZE-1:0] w_tx_word;

  assign w_in_frame = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
  assign w_rx_shift = !SS_n && w_in_frame && (r_cnt != c_DONE);
  // Only the first tx_valid after the command completes is accepted per frame.
  assign w_tx_load  = !SS_n && (r_state == READ_DATA) && (r_cnt == c_DONE) &&
                      !r_tx_loaded && tx_valid;
  assign w_tx_shift = !SS_n && (|w_tx_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= IDLE;
      r_cnt              <= '0;
      r_rx_valid         <= 1'b0;
      r_rd_addr_received <= 1'b0;
      r_tx_loaded        <= 1'b0;
    end else if (SS_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_loaded <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state <= CHK_CMD;
          r_cnt   <= '0;
        end
        CHK_CMD: begin
          if (!MOSI)                   r_state <= WRITE;
          else if (r_rd_addr_received) r_state <= READ_DATA;
          else                         r_state <= READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (w_rx_shift) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
              r_rx_valid <= 1'b1;
              if (r_state == READ_ADD) r_rd_addr_received <= 1'b1;
            end
          end
          if (w_tx_load) begin
            r_tx_loaded        <= 1'b1;
            r_rd_addr_received <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  spi_shift_reg #(.WIDTH(c_FRAME_BITS)) u_rx_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (SS_n),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_shift     (w_rx_shift),
    .i_sdata     (MOSI),
    .o_data      (rx_data)
  );

  // Zeros shift in behind the byte, so MISO returns to 0 after bit 0.
  spi_shift_reg #(.WIDTH(ADDR_SIZE)) u_tx_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (SS_n),
    .i_load      (w_tx_load),
    .i_load_data (tx_data),
    .i_shift     (w_tx_shift),
    .i_sdata     (1'b0),
    .o_data      (w_tx_word)
  );

  assign MISO     = w_tx_word[ADDR_SIZE-1];
  assign rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_slave : scoreboard bench for spi_slave with a one-port RAM model.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       MOSI;
  logic       SS_n;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int c0      = 0;

  logic [9:0] exp_rx_q[$];
  logic [9:0] obs_rx_q[$];
  int         exp_cyc_q[$];
  int         obs_cyc_q[$];
  logic       exp_miso_q[$];
  logic       obs_miso_q[$];

  int         ram_delay  = 1;
  bit         ram_double = 1'b0;
  logic [7:0] ram_byte   = 8'h00;
  int         r_dly      = 0;
  int         r_dly2     = 0;

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MOSI     (MOSI),
    .SS_n     (SS_n),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: answers a read-data command after ram_delay cycles, optionally twice.
  always @(posedge clk) begin
    if (rx_valid && rx_data[9:8] == RD_DATA) begin
      r_dly  <= ram_delay;
      r_dly2 <= ram_double ? ram_delay + 9 : 0;
    end else begin
      if (r_dly != 0)  r_dly  <= r_dly - 1;
      if (r_dly2 != 0) r_dly2 <= r_dly2 - 1;
    end
  end
  assign tx_valid = (r_dly == 1) || (r_dly2 == 1);
  assign tx_data  = (r_dly2 == 1) ? 8'hFF : ram_byte;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      obs_rx_q.push_back(rx_data);
      obs_cyc_q.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic cmd, input logic [9:0] word, input int nbits, input int extra);
    c0   = cyc;
    SS_n = 1'b0;
    MOSI = 1'b0;
    obs_miso_q.push_back(MISO); exp_miso_q.push_back(1'b0); step();
    MOSI = cmd;
    obs_miso_q.push_back(MISO); exp_miso_q.push_back(1'b0); step();
    for (int i = 0; i < nbits; i++) begin
      MOSI = word[9-i];
      obs_miso_q.push_back(MISO); exp_miso_q.push_back(1'b0); step();
    end
    for (int i = 0; i < extra; i++) begin
      MOSI = 1'($urandom);
      obs_miso_q.push_back(MISO); exp_miso_q.push_back(1'b0); step();
    end
    if (nbits == 10) begin
      exp_rx_q.push_back(word);
      exp_cyc_q.push_back(c0 + 12);
    end
  endtask

  task automatic collect_miso(input int n);
    for (int i = 0; i < n; i++) begin
      obs_miso_q.push_back(MISO);
      step();
    end
  endtask

  task automatic expect_byte(input int n, input int d, input logic [7:0] b);
    for (int k = 0; k < n; k++)
      exp_miso_q.push_back((k >= 1 + d && k < 9 + d) ? b[7-(k-1-d)] : 1'b0);
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    n_total++;
    if (MISO !== 1'b0) $display("FAIL reset_miso: got %b expected 0", MISO);
    else n_pass++;
    n_total++;
    if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid);
    else n_pass++;
    n_total++;
    if (rx_data !== 10'h000) $display("FAIL reset_rx_data: got %h expected 000", rx_data);
    else n_pass++;
  endtask

  task automatic test_write_addr();
    logic [9:0] ew, ow;
    int ec, oc;
    send_frame(1'b0, 10'h0A5, 10, 2);
    collect_miso(3); expect_byte(3, 20, 8'h00);
    end_frame();
    n_total++;
    if (obs_rx_q.size() !== exp_rx_q.size())
      $display("FAIL wr_addr_pulses: got %0d expected %0d", obs_rx_q.size(), exp_rx_q.size());
    else n_pass++;
    while (exp_rx_q.size() > 0 && obs_rx_q.size() > 0) begin
      ew = exp_rx_q.pop_front(); ow = obs_rx_q.pop_front();
      ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
      n_total++;
      if (ow !== ew) $display("FAIL wr_addr_word: got %h expected %h", ow, ew); else n_pass++;
      n_total++;
      if (oc !== ec) $display("FAIL wr_addr_cycle: got %0d expected %0d", oc, ec); else n_pass++;
    end
    n_total++;
    if (obs_miso_q !== exp_miso_q) $display("FAIL wr_addr_miso: MISO not held at 0 during write frame");
    else n_pass++;
    exp_rx_q.delete(); obs_rx_q.delete(); exp_cyc_q.delete(); obs_cyc_q.delete();
    exp_miso_q.delete(); obs_miso_q.delete();
  endtask

  task automatic test_write_data();
    logic [9:0] ew, ow;
    int ec, oc;
    send_frame(1'b0, 10'h13C, 10, 5);
    end_frame();
    n_total++;
    if (obs_rx_q.size() !== exp_rx_q.size())
      $display("FAIL wr_data_pulses: got %0d expected %0d", obs_rx_q.size(), exp_rx_q.size());
    else n_pass++;
    while (exp_rx_q.size() > 0 && obs_rx_q.size() > 0) begin
      ew = exp_rx_q.pop_front(); ow = obs_rx_q.pop_front();
      ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
      n_total++;
      if (ow !== ew) $display("FAIL wr_data_word: got %h expected %h", ow, ew); else n_pass++;
      n_total++;
      if (oc !== ec) $display("FAIL wr_data_cycle: got %0d expected %0d", oc, ec); else n_pass++;
    end
    exp_rx_q.delete(); obs_rx_q.delete(); exp_cyc_q.delete(); obs_cyc_q.delete();
    exp_miso_q.delete(); obs_miso_q.delete();
  endtask

  task automatic test_read(input string name, input logic [9:0] word, input int n,
                           input int d, input logic [7:0] b);
    logic [9:0] ew, ow;
    int ec, oc;
    logic em, om;
    send_frame(1'b1, word, 10, 0);
    collect_miso(n); expect_byte(n, d, b);
    end_frame();
    n_total++;
    if (obs_rx_q.size() !== exp_rx_q.size())
      $display("FAIL %s_pulses: got %0d expected %0d", name, obs_rx_q.size(), exp_rx_q.size());
    else n_pass++;
    while (exp_rx_q.size() > 0 && obs_rx_q.size() > 0) begin
      ew = exp_rx_q.pop_front(); ow = obs_rx_q.pop_front();
      ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
      n_total++;
      if (ow !== ew) $display("FAIL %s_word: got %h expected %h", name, ow, ew); else n_pass++;
      n_total++;
      if (oc !== ec) $display("FAIL %s_cycle: got %0d expected %0d", name, oc, ec); else n_pass++;
    end
    for (int k = 0; exp_miso_q.size() > 0 && obs_miso_q.size() > 0; k++) begin
      em = exp_miso_q.pop_front(); om = obs_miso_q.pop_front();
      n_total++;
      if (om !== em) $display("FAIL %s_miso[%0d]: got %b expected %b", name, k, om, em);
      else n_pass++;
    end
    exp_rx_q.delete(); obs_rx_q.delete(); exp_cyc_q.delete(); obs_cyc_q.delete();
    exp_miso_q.delete(); obs_miso_q.delete();
  endtask

  task automatic test_read_addr_data();
    ram_delay = 1;
    test_read("rd_addr", 10'h207, 3, 20, 8'h00);
    ram_byte = 8'hC3;
    test_read("rd_data", 10'h35A, 12, 1, 8'hC3);
    // rd_addr_received is now clear: this frame is a READ_ADD and must ignore the RAM reply
    ram_byte = 8'h81;
    test_read("rd_after", 10'h3AA, 12, 20, 8'h00);
  endtask

  task automatic test_abort();
    logic [9:0] ew, ow;
    send_frame(1'b0, 10'h155, 5, 0);
    end_frame();
    send_frame(1'b0, 10'h0F0, 10, 0);
    end_frame();
    send_frame(1'b1, 10'h3FF, 5, 0);
    end_frame();
    n_total++;
    if (obs_rx_q.size() !== exp_rx_q.size())
      $display("FAIL abort_pulses: got %0d expected %0d", obs_rx_q.size(), exp_rx_q.size());
    else n_pass++;
    while (exp_rx_q.size() > 0 && obs_rx_q.size() > 0) begin
      ew = exp_rx_q.pop_front(); ow = obs_rx_q.pop_front();
      n_total++;
      if (ow !== ew) $display("FAIL abort_word: got %h expected %h", ow, ew); else n_pass++;
    end
    n_total++;
    if (obs_miso_q !== exp_miso_q) $display("FAIL abort_miso: MISO not held at 0");
    else n_pass++;
    exp_rx_q.delete(); obs_rx_q.delete(); exp_cyc_q.delete(); obs_cyc_q.delete();
    exp_miso_q.delete(); obs_miso_q.delete();
  endtask

  task automatic test_delayed_read();
    // rd_addr_received survives the aborted read frame, so this is a READ_DATA frame
    ram_byte   = 8'hA6;
    ram_delay  = 4;
    ram_double = 1'b1;
    test_read("rd_delay", 10'h3C0, 17, 4, 8'hA6);
    ram_double = 1'b0;
    ram_delay  = 1;
  endtask

  task automatic test_reset_mid();
    test_read("rst_addr", 10'h207, 3, 20, 8'h00);
    ram_byte = 8'hFF;
    send_frame(1'b1, 10'h3C3, 10, 0);
    collect_miso(5);
    n_total++;
    if (obs_miso_q.size() < 17 || obs_miso_q[14] !== 1'b1 || obs_miso_q[16] !== 1'b1)
      $display("FAIL rst_pre_miso: read byte not shifting before reset (%0d samples)", obs_miso_q.size());
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (MISO !== 1'b0) $display("FAIL rst_mid_miso: got %b expected 0", MISO); else n_pass++;
    n_total++;
    if (rx_valid !== 1'b0) $display("FAIL rst_mid_rx_valid: got %b expected 0", rx_valid); else n_pass++;
    n_total++;
    if (rx_data !== 10'h000) $display("FAIL rst_mid_rx_data: got %h expected 000", rx_data); else n_pass++;
    SS_n = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    exp_rx_q.delete(); obs_rx_q.delete(); exp_cyc_q.delete(); obs_cyc_q.delete();
    exp_miso_q.delete(); obs_miso_q.delete();
    ram_byte = 8'h81;
    test_read("rst_after", 10'h3AA, 12, 20, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_write_addr();
    test_write_data();
    test_read_addr_data();
    test_abort();
    test_delayed_read();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
